// File: rtl/ram_fifo_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ram_fifo_ctrl
//   FIFO controller around an external dual-port RAM (raminfr style).
//   Port A writes, and port B performs a synchronous read: the word addressed
//   at an edge appears on ram_rdata after that edge. The controller owns the
//   read and write pointers, the occupancy count and the valid/ready
//   handshakes.
//
// Ports
//   clk1       : sole clock, rising edge
//   rst        : asynchronous, active-high reset
//   in_valid   : producer offers in_data
//   in_data    : write data
//   in_ready   : a word is accepted this cycle (not full, not in reset)
//   out_valid  : out_data holds the head entry
//   out_data   : head entry, taken straight from ram_rdata
//   out_ready  : consumer takes the head this cycle
//   ram_we     : RAM write enable (port A)
//   ram_waddr  : RAM write address (port A)
//   ram_wdata  : RAM write data (port A)
//   ram_raddr  : RAM read address (port B)
//   ram_rdata  : RAM read data (port B), one edge after ram_raddr
//   count      : stored entries, 0..2**AW
//   full       : count == 2**AW
//   empty      : count == 0
// ---------------------------------------------------------------------------

// Invariant checker, kept apart from the datapath.
module ram_fifo_ctrl_chk #(
  parameter int AW = 5
) (
  input logic          clk1,
  input logic          rst,
  input logic          in_ready,
  input logic          out_valid,
  input logic          out_ready,
  input logic          full,
  input logic          empty,
  input logic [AW:0]   count,
  input logic [AW-1:0] ram_raddr,
  input logic [AW-1:0] rd_ptr
);
  localparam int unsigned DEPTH_I = 1 << AW;
  localparam logic [AW:0] DEPTH   = DEPTH_I[AW:0];
  localparam logic [AW:0] CNT_ZERO = {(AW+1){1'b0}};

  a_valid_has_data: assert property (@(posedge clk1) disable iff (rst)
    out_valid |-> (count != CNT_ZERO));
  a_no_overfill: assert property (@(posedge clk1) disable iff (rst)
    count <= DEPTH);
  a_full_blocks: assert property (@(posedge clk1) disable iff (rst)
    full |-> !in_ready);
  a_full_flag: assert property (@(posedge clk1) disable iff (rst)
    full == (count == DEPTH));
  a_empty_flag: assert property (@(posedge clk1) disable iff (rst)
    empty == (count == CNT_ZERO));
  a_hold_addr: assert property (@(posedge clk1) disable iff (rst)
    !(out_valid && out_ready) |-> (ram_raddr == rd_ptr));
endmodule

module ram_fifo_ctrl #(
  parameter int DW = 4,
  parameter int AW = 5
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wdata,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  localparam int unsigned DEPTH_I  = 1 << AW;
  localparam logic [AW:0]   DEPTH    = DEPTH_I[AW:0];
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          out_valid_r;
  logic          full_r;
  logic          empty_r;

  logic          push_s;
  logic          pop_s;
  logic [AW-1:0] raddr_s;
  logic [AW:0]   count_next_s;
  logic          valid_next_s;

  // Handshakes, read address look-ahead and next-state values.
  always_comb begin
    push_s       = in_valid && !full_r && !rst;
    pop_s        = out_valid_r && out_ready;
    raddr_s      = rd_ptr_r;
    count_next_s = count_r;
    valid_next_s = 1'b0;

    // On a pop the RAM must already fetch the next entry so it is on
    // ram_rdata right after the edge; otherwise keep re-reading the head.
    if (pop_s) begin
      raddr_s = rd_ptr_r + PTR_ONE;
    end else begin
      raddr_s = rd_ptr_r;
    end

    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase

    // A word pushed on this edge is deliberately not counted: it is only
    // readable one edge later, which avoids reading an address that is
    // being written on the same edge.
    if (pop_s) begin
      valid_next_s = (count_r != CNT_ONE);
    end else begin
      valid_next_s = (count_r != CNT_ZERO);
    end
  end

  // Pointer, occupancy and status registers.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      out_valid_r <= 1'b0;
      full_r      <= 1'b0;
      empty_r     <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r     <= count_next_s;
      out_valid_r <= valid_next_s;
      full_r      <= (count_next_s == DEPTH);
      empty_r     <= (count_next_s == CNT_ZERO);
    end
  end

  assign in_ready  = !full_r && !rst;
  assign out_valid = out_valid_r;
  assign out_data  = ram_rdata;
  assign ram_we    = push_s;
  assign ram_waddr = wr_ptr_r;
  assign ram_wdata = in_data;
  assign ram_raddr = raddr_s;
  assign count     = count_r;
  assign full      = full_r;
  assign empty     = empty_r;

  ram_fifo_ctrl_chk #(.AW(AW)) u_chk (
    .clk1      (clk1),
    .rst       (rst),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .ram_raddr (ram_raddr),
    .rd_ptr    (rd_ptr_r)
  );
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
`timescale 1ns/1ps
// Testbench for ram_fifo_ctrl: a behavioural synchronous-read RAM, a small
// reference model feeding an expected-data queue, a negedge monitor that
// pops and compares, and directed scenarios with hand-computed checkpoints.
module tb_ram_fifo_ctrl;
  localparam int DW = 4;
  localparam int AW = 5;

  logic          clk1 = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = 4'h0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;
  logic [AW:0]   count;
  logic          full;
  logic          empty;

  int checks = 0;
  int failures = 0;

  ram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk1      (clk1),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk1 = ~clk1;

  // Synchronous-read RAM (old data on read-during-write).
  logic [DW-1:0] mem [0:31];
  always @(posedge clk1) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of the FIFO behaviour.
  logic [5:0]    m_count;
  logic [4:0]    m_wr;
  logic [4:0]    m_rd;
  logic          m_valid;
  logic          m_push;
  logic          m_pop;
  logic [4:0]    exp_raddr;
  logic [DW-1:0] exp_q [$];

  always_comb begin
    m_push    = in_valid && (m_count != 6'd32);
    m_pop     = m_valid && out_ready;
    exp_raddr = m_rd + {4'd0, m_pop};
  end

  always @(posedge clk1 or posedge rst) begin
    if (rst) begin
      m_count <= 6'd0;
      m_wr    <= 5'd0;
      m_rd    <= 5'd0;
      m_valid <= 1'b0;
      exp_q.delete();
    end else begin
      if (m_push) exp_q.push_back(in_data);
      m_valid <= (m_count - {5'd0, m_pop}) != 6'd0;
      m_count <= m_count + {5'd0, m_push} - {5'd0, m_pop};
      m_wr    <= m_wr + {4'd0, m_push};
      m_rd    <= m_rd + {4'd0, m_pop};
    end
  end

  // Monitor: compares status every cycle and data whenever a pop is due.
  always @(negedge clk1) begin
    if (!rst) begin
      check("out_valid", out_valid, m_valid);
      check("count", count, m_count);
      check("full", full, m_count == 6'd32);
      check("empty", empty, m_count == 6'd0);
      check("in_ready", in_ready, m_count != 6'd32);
      check("ram_we", ram_we, m_push);
      if (m_push) check("ram_waddr", ram_waddr, m_wr);
      check("ram_raddr", ram_raddr, exp_raddr);
      if (m_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_data actual=%0h expected=<none queued>", out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk1);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk1);
      if (empty === 1'b1 && out_valid === 1'b0) break;
    end
    check({tag, "_drain_empty"}, empty, 1'b1);
    check({tag, "_drain_queue"}, exp_q.size(), 0);
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  int maxc;

  initial begin
    // Single word: latency and first address after reset.
    do_reset();
    @(negedge clk1);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    tick();
    in_valid = 1'b1; in_data = 4'ha; out_ready = 1'b1;
    @(negedge clk1);
    check("t1_we", ram_we, 1'b1);
    check("t1_waddr", ram_waddr, 0);
    tick(); in_valid = 1'b0;
    @(negedge clk1);
    check("t1_cnt_n", count, 1);
    check("t1_valid_n", out_valid, 1'b0);
    tick();
    @(negedge clk1);
    check("t1_valid_n1", out_valid, 1'b1);
    check("t1_data_n1", out_data, 4'ha);
    check("t1_cnt_n1", count, 1);
    tick();
    @(negedge clk1);
    check("t1_cnt_n2", count, 0);
    check("t1_empty_n2", empty, 1'b1);

    // Fill to full, try a 33rd word, then drain in order.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1; in_data = 4'(i);
      tick();
    end
    in_data = 4'hf;
    @(negedge clk1);
    check("t2_full", full, 1'b1);
    check("t2_in_ready", in_ready, 1'b0);
    check("t2_count", count, 32);
    check("t2_no_we", ram_we, 1'b0);
    drain("t2");

    // Streaming 80 words: pointers wrap twice, occupancy stays tiny.
    do_reset();
    out_ready = 1'b1;
    maxc = 0;
    for (int i = 0; i < 80; i++) begin
      in_valid = 1'b1; in_data = 4'(i * 3 + 1);
      @(negedge clk1);
      if (int'(count) > maxc) maxc = int'(count);
      tick();
    end
    check("t3_max_count", maxc, 2);
    drain("t3");

    // Full with pop: pop only, push resumes the cycle after full drops.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1; in_data = 4'(i + 5);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      out_ready = 1'b1;
      @(negedge clk1);
      check("t4_full_cnt", count, 32);
      check("t4_full_no_we", ram_we, 1'b0);
      tick();
      out_ready = 1'b0;
      @(negedge clk1);
      check("t4_cnt31", count, 31);
      check("t4_push_we", ram_we, 1'b1);
      tick();
    end
    @(negedge clk1);
    check("t4_refull", count, 32);
    drain("t4");

    // Stall: head word and read address hold.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 4'(i + 5);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk1);
      check("t5_valid", out_valid, 1'b1);
      check("t5_data", out_data, 4'h5);
      check("t5_raddr", ram_raddr, 0);
      check("t5_count", count, 3);
      tick();
    end
    drain("t5");

    // Asynchronous reset with 10 stored words.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 4'(i + 1);
      tick();
    end
    in_data = 4'h3;
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", out_valid, 1'b0);
    check("t6_rst_count", count, 0);
    check("t6_rst_we", ram_we, 1'b0);
    check("t6_rst_in_ready", in_ready, 1'b0);
    check("t6_rst_empty", empty, 1'b1);
    tick();
    rst = 1'b0; in_valid = 1'b1; in_data = 4'hb; out_ready = 1'b0;
    @(negedge clk1);
    check("t6_we", ram_we, 1'b1);
    check("t6_waddr", ram_waddr, 0);
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk1);
    check("t6_count1", count, 1);
    for (int k = 0; k < 5; k++) begin
      if (out_valid === 1'b1) break;
      @(negedge clk1);
    end
    check("t6_valid", out_valid, 1'b1);
    check("t6_data", out_data, 4'hb);
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
